// File: rtl/rgb_pkg.sv
// rgb_pkg: shared one-hot/index encodings and monitor FSM states for the RGB light path.
package rgb_pkg;
  localparam logic [2:0] RED_OH = 3'b100;
  localparam logic [2:0] GREEN_OH = 3'b010;
  localparam logic [2:0] BLUE_OH = 3'b001;
  localparam logic [1:0] RED_IX = 2'd0;
  localparam logic [1:0] GREEN_IX = 2'd1;
  localparam logic [1:0] BLUE_IX = 2'd2;
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
  function automatic logic [1:0] next_ix(input logic [1:0] ix);
    return (ix == BLUE_IX) ? RED_IX : ix + 2'd1;
  endfunction
endpackage

// File: rtl/rgb_onehot_decode.sv
// rgb_onehot_decode: combinational one-hot light code to colour index with legality flag.
module rgb_onehot_decode
  import rgb_pkg::*;
(
  input  logic [2:0] light,
  output logic [1:0] idx,
  output logic       legal
);
  always_comb begin
    legal = (light == RED_OH) || (light == GREEN_OH) || (light == BLUE_OH);
    idx = (light == GREEN_OH) ? GREEN_IX : (light == BLUE_OH) ? BLUE_IX : RED_IX;
  end
endmodule

// File: rtl/rgb_light_monitor.sv
// rgb_light_monitor: locks onto RED->GREEN->BLUE rotation, counts rotations, flags errors.
// Define RGB_ERR_COUNT_EN to add a saturating err_count output.
module rgb_light_monitor
  import rgb_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [2:0]       light,
  output logic [1:0]       color,
  output logic             color_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             code_err,
  output logic [CNT_W-1:0] rot_count
`ifdef RGB_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  state_t state, state_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [1:0] idx, color_n;
  logic legal, expected, valid_n, seq_n, code_n, rot_inc;
  rgb_onehot_decode u_dec (
    .light(light),
    .idx(idx),
    .legal(legal)
  );
  assign expected = legal && (idx == next_ix(color));
  assign locked = (state == LOCKED);
  always_comb begin
    state_n = state;
    match_n = match_cnt;
    color_n = sample_en && legal ? idx : color;
    valid_n = sample_en ? legal : color_valid;
    seq_n = 1'b0;
    code_n = sample_en && !legal;
    rot_inc = 1'b0;
    if (sample_en && !legal) state_n = HUNT;
    else if (sample_en) begin
      case (state)
        HUNT: begin
          state_n = SYNC;
          match_n = '0;
        end
        SYNC: begin
          match_n = expected ? match_cnt + 1'b1 : '0;
          state_n = expected && (match_n == MW'(LOCK_COUNT)) ? LOCKED : SYNC;
        end
        LOCKED: begin
          // Entering LOCKED happens in SYNC, so a 2->0 there never bumps rot_count.
          rot_inc = expected && (color == BLUE_IX);
          seq_n = !expected;
          state_n = expected ? LOCKED : SYNC;
          match_n = expected ? match_cnt : '0;
        end
        default: state_n = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      match_cnt <= '0;
      color <= '0;
      color_valid <= 1'b0;
      seq_err <= 1'b0;
      code_err <= 1'b0;
      rot_count <= '0;
    end else begin
      state <= state_n;
      match_cnt <= match_n;
      color <= color_n;
      color_valid <= valid_n;
      seq_err <= seq_n;
      code_err <= code_n;
      rot_count <= rot_count + CNT_W'(rot_inc);
    end
  end
`ifdef RGB_ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count <= '0;
    else if ((seq_n || code_n) && (err_count != '1)) err_count <= err_count + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_rgb_light_monitor.sv
// tb_rgb_light_monitor: scoreboard bench for rgb_light_monitor (LOCK_COUNT=3, CNT_W=2).
module tb_rgb_light_monitor;
  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0;
  logic [2:0] light = 3'b000;
  logic [1:0] color, rot_count;
  logic color_valid, locked, seq_err, code_err;
`ifdef RGB_ERR_COUNT_EN
  logic [1:0] err_count;
`endif
  typedef struct packed {
    logic [1:0] color;
    logic valid, locked, seq, code;
    logic [1:0] rot;
`ifdef RGB_ERR_COUNT_EN
    logic [1:0] err;
`endif
  } obs_t;
  obs_t exp_q[$], obs_q[$];
  int checks = 0, fails = 0;
  logic [1:0] err_m = 2'd0;

  rgb_light_monitor #(.LOCK_COUNT(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .light(light),
    .color(color), .color_valid(color_valid), .locked(locked),
    .seq_err(seq_err), .code_err(code_err), .rot_count(rot_count)
`ifdef RGB_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic obs_t cur();
    obs_t o;
    o.color = color; o.valid = color_valid; o.locked = locked;
    o.seq = seq_err; o.code = code_err; o.rot = rot_count;
`ifdef RGB_ERR_COUNT_EN
    o.err = err_count;
`endif
    return o;
  endfunction

  function automatic obs_t mk(input logic [1:0] c, input logic v, lk, s, cd, input logic [1:0] r);
    obs_t e;
    e.color = c; e.valid = v; e.locked = lk; e.seq = s; e.code = cd; e.rot = r;
`ifdef RGB_ERR_COUNT_EN
    e.err = err_m;
`endif
    return e;
  endfunction

  task automatic apply(input logic [2:0] l, input logic en, input logic [1:0] c,
                       input logic v, lk, s, cd, input logic [1:0] r);
    light = l;
    sample_en = en;
    if (rst) err_m = 2'd0;
    else if ((s || cd) && err_m != 2'd3) err_m = err_m + 2'd1;
    exp_q.push_back(mk(c, v, lk, s, cd, r));
    @(posedge clk);
    #1;
    obs_q.push_back(cur());
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) apply(3'b111, 1'b1, 2'd0, 0, 0, 0, 0, 2'd0);
    rst = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e = exp_q.pop_front(), g = obs_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL reset step %0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_lock();
    apply(3'b100, 1, 2'd0, 1, 0, 0, 0, 2'd0);
    apply(3'b010, 1, 2'd1, 1, 0, 0, 0, 2'd0);
    apply(3'b001, 1, 2'd2, 1, 0, 0, 0, 2'd0);
    apply(3'b100, 1, 2'd0, 1, 1, 0, 0, 2'd0);
    apply(3'b010, 1, 2'd1, 1, 1, 0, 0, 2'd0);
    apply(3'b001, 1, 2'd2, 1, 1, 0, 0, 2'd0);
    apply(3'b100, 1, 2'd0, 1, 1, 0, 0, 2'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e = exp_q.pop_front(), g = obs_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL lock step %0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_seq_err();
    apply(3'b001, 1, 2'd2, 1, 0, 1, 0, 2'd1);
    apply(3'b100, 1, 2'd0, 1, 0, 0, 0, 2'd1);
    apply(3'b010, 1, 2'd1, 1, 0, 0, 0, 2'd1);
    apply(3'b001, 1, 2'd2, 1, 1, 0, 0, 2'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e = exp_q.pop_front(), g = obs_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL seq_err step %0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_code_err();
    apply(3'b000, 1, 2'd2, 0, 0, 0, 1, 2'd1);
    apply(3'b111, 1, 2'd2, 0, 0, 0, 1, 2'd1);
    apply(3'b101, 1, 2'd2, 0, 0, 0, 1, 2'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e = exp_q.pop_front(), g = obs_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL code_err step %0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_sample_en();
    apply(3'b010, 1, 2'd1, 1, 0, 0, 0, 2'd1);
    apply(3'b100, 0, 2'd1, 1, 0, 0, 0, 2'd1);
    apply(3'b000, 0, 2'd1, 1, 0, 0, 0, 2'd1);
    apply(3'b001, 1, 2'd2, 1, 0, 0, 0, 2'd1);
    apply(3'b100, 1, 2'd0, 1, 0, 0, 0, 2'd1);
    apply(3'b010, 1, 2'd1, 1, 1, 0, 0, 2'd1);
    apply(3'b110, 0, 2'd1, 1, 1, 0, 0, 2'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e = exp_q.pop_front(), g = obs_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL sample_en step %0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] r = 2'd2;
    apply(3'b001, 1, 2'd2, 1, 1, 0, 0, 2'd1);
    apply(3'b100, 1, 2'd0, 1, 1, 0, 0, r);
    for (int k = 0; k < 4; k++) begin
      apply(3'b010, 1, 2'd1, 1, 1, 0, 0, r);
      apply(3'b001, 1, 2'd2, 1, 1, 0, 0, r);
      r = r + 2'd1;
      apply(3'b100, 1, 2'd0, 1, 1, 0, 0, r);
    end
    apply(3'b100, 1, 2'd0, 1, 0, 1, 0, r);
    apply(3'b010, 1, 2'd1, 1, 0, 0, 0, r);
    apply(3'b001, 1, 2'd2, 1, 0, 0, 0, r);
    apply(3'b100, 1, 2'd0, 1, 1, 0, 0, r);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e = exp_q.pop_front(), g = obs_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL wrap step %0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    apply(3'b010, 1, 2'd1, 1, 1, 0, 0, 2'd2);
    #2;
    rst = 1'b1;
    err_m = 2'd0;
    #1;
    exp_q.push_back(mk(2'd0, 0, 0, 0, 0, 2'd0));
    obs_q.push_back(cur());
    apply(3'b001, 1, 2'd0, 0, 0, 0, 0, 2'd0);
    rst = 1'b0;
    apply(3'b100, 1, 2'd0, 1, 0, 0, 0, 2'd0);
    apply(3'b010, 1, 2'd1, 1, 0, 0, 0, 2'd0);
    apply(3'b001, 1, 2'd2, 1, 0, 0, 0, 2'd0);
    apply(3'b100, 1, 2'd0, 1, 1, 0, 0, 2'd0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      obs_t e = exp_q.pop_front(), g = obs_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL reset_mid step %0d: got %h expected %h", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_seq_err();
    test_code_err();
    test_sample_en();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rgb_light_monitor.md
Name: rgb_light_monitor

Overview:
- Receiving end of the one-hot RGB light stream. Samples a 3-bit one-hot `light` bus and decodes it to a colour index.
- Locks onto the fixed RED->GREEN->BLUE->RED rotation, then counts completed rotations and flags illegal codes or out-of-order colours.
- Sits beside any light-cycler output, as a checker in the system or as a bench monitor.

Parameters:
- LOCK_COUNT, 3: consecutive in-order transitions needed to reach LOCKED; legal range >= 1.
- CNT_W, 8: width of the rotation counter (and of the error counter when enabled).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  when high, `light` is sampled on this edge; when low, the monitor holds.
- light  input  3  one-hot colour: 3'b100 RED, 3'b010 GREEN, 3'b001 BLUE.
- color  output  2  decoded index: 0 RED, 1 GREEN, 2 BLUE.
- color_valid  output  1  high once a legal code has been sampled since the last HUNT entry.
- locked  output  1  high while the FSM is in LOCKED.
- seq_err  output  1  one-cycle pulse: legal but out-of-order colour while LOCKED.
- code_err  output  1  one-cycle pulse: illegal code sampled, in any state.
- rot_count  output  CNT_W  count of completed rotations (BLUE->RED transitions) while LOCKED.

Behaviour:
- Reset: asserting rst forces all outputs to 0 immediately and the FSM to HUNT. This holds mid-operation, regardless of sample_en.
- Latency: every output is registered and reflects the `light` sampled on the same rising edge. Visible one cycle after the sample is presented.
- sample_en = 0: the state, color, color_valid, locked and rot_count hold; seq_err and code_err are 0.
- Decode:
  - Legal codes are exactly 100, 010 and 001.
  - Anything else (000, 011, 101, 110, 111) is illegal: code_err = 1, color holds its previous value, color_valid = 0.
- Expected next colour = (prev + 1) mod 3, i.e. 0->1->2->0. A repeat of the same colour counts as out-of-order.
- FSM states: HUNT, SYNC, LOCKED. Each row below applies to an edge with sample_en = 1:
  - HUNT + legal: color <= idx, color_valid <= 1, match_cnt <= 0, go to SYNC.
  - HUNT + illegal: stay in HUNT, pulse code_err.
  - SYNC + expected: match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked = 1 on that edge.
  - SYNC + legal, not expected: re-anchor on the new colour, match_cnt <= 0, stay in SYNC. No seq_err.
  - SYNC + illegal: go to HUNT, pulse code_err.
  - LOCKED + expected: stay in LOCKED. If the transition is 2->0, rot_count++.
  - LOCKED + legal, not expected: pulse seq_err, locked <= 0, go to SYNC, match_cnt <= 0, color <= new idx.
  - LOCKED + illegal: pulse code_err, locked <= 0, go to HUNT.
- rot_count:
  - Increments only in LOCKED; it wraps from 2^CNT_W-1 to 0.
  - It is not cleared on loss of lock; only rst clears it.
  - The transition that enters LOCKED never increments it, even if that transition is 2->0.
- match_cnt width is $clog2(LOCK_COUNT+1). LOCK_COUNT = 1 locks on the first in-order transition.
- seq_err and code_err are mutually exclusive by construction.

Optional Feature:
- Macro: RGB_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [CNT_W-1:0], reset 0.
  - Increments on every seq_err or code_err pulse and saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Undefined: no port, no counter logic. All other behaviour is identical.

Decomposition:
- Shared package rgb_pkg holds:
  - One-hot constants RED_OH = 3'b100, GREEN_OH = 3'b010, BLUE_OH = 3'b001.
  - Index constants RED_IX = 0, GREEN_IX = 1, BLUE_IX = 2.
  - The FSM state enum {HUNT, SYNC, LOCKED}.
- Sub-module rgb_onehot_decode, purely combinational: light[2:0] -> idx[1:0] and legal. It is reusable by other light-path blocks.

Test Plan:
- rst = 1, light = 111, sample_en = 1 for 3 cycles -> all outputs 0, state HUNT, no code_err while rst is high.
- Cycler sequence 100,010,001,100 with sample_en = 1 every cycle, LOCK_COUNT = 3 -> locked rises on the 4th sample, rot_count = 0. The next 010,001,100 -> rot_count = 1.
- While locked, inject 001 where 010 is expected -> seq_err pulses 1 cycle, locked = 0, color = 2. Then 100,010,001 -> locked again.
- While locked, inject 000 -> code_err pulse, color holds its last value, color_valid = 0, state HUNT. With RGB_ERR_COUNT_EN, err_count = 1.
- sample_en toggled 1,0,0,1 with light changing while sample_en = 0 -> outputs hold; only sampled values affect the sequence.
- CNT_W = 2, 5 full rotations while locked -> rot_count wraps 3->0 and ends at 1. Assert rst mid-rotation -> immediate clear, relock needs LOCK_COUNT transitions.
